// File: rtl/l1_cache_arbiter.sv
// Round-robin two-port sequencer in front of a 2-way write-back L1 cache.
// Holds each granted request on the cache until it hits (or gives up) and returns a one-cycle ack.
module l1_cache_arbiter #(
    parameter int MAX_TRIES = 6
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req0,
    input  logic       req1,
    input  logic [4:0] addr0,
    input  logic [4:0] addr1,
    input  logic [2:0] wdata0,
    input  logic [2:0] wdata1,
    input  logic       we0,
    input  logic       we1,
    output logic       ack0,
    output logic       ack1,
    output logic [2:0] rdata,
    output logic       err,
    output logic       busy,
    output logic [4:0] cache_address,
    output logic [2:0] cache_data,
    output logic       cache_wren,
    input  logic [2:0] cache_dataOUT,
    input  logic       cache_hit,
    input  logic       cache_write_back_en,
    output logic [7:0] miss_count,
    output logic [7:0] wb_count
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [2:0] TRY_LAST = 3'(MAX_TRIES - 1);

    state_t     state_q;
    logic [2:0] try_q;
    logic       last_grant_q;
    logic       ack0_q;
    logic       ack1_q;
    logic       err_q;
    logic       busy_q;
    logic [2:0] rdata_q;
    logic [4:0] addr_q;
    logic [2:0] data_q;
    logic       wren_q;
    logic [7:0] miss_q;
    logic [7:0] wb_q;

    logic       grant_d;
    logic [7:0] miss_d;
    logic [7:0] wb_d;

    // A tie goes to whoever was not served last; a lone request always wins.
    always_comb begin
        grant_d = last_grant_q;
        if (req0 && req1) begin
            grant_d = ~last_grant_q;
        end else if (req0) begin
            grant_d = 1'b0;
        end else if (req1) begin
            grant_d = 1'b1;
        end

        miss_d = miss_q;
        if ((try_q == 3'd0) && !cache_hit && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
        end

        wb_d = wb_q;
        if (cache_write_back_en && (wb_q != 8'hFF)) begin
            wb_d = wb_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= IDLE;
            try_q        <= 3'd0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            rdata_q      <= 3'd0;
            addr_q       <= 5'd0;
            data_q       <= 3'd0;
            wren_q       <= 1'b0;
            miss_q       <= 8'd0;
            wb_q         <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        last_grant_q <= grant_d;
                        addr_q       <= grant_d ? addr1 : addr0;
                        data_q       <= grant_d ? wdata1 : wdata0;
                        wren_q       <= grant_d ? we1 : we0;
                        try_q        <= 3'd0;
                        busy_q       <= 1'b1;
                        state_q      <= BUSY;
                    end else begin
                        wren_q <= 1'b0;
                    end
                end
                BUSY: begin
                    // Cache inputs stay frozen so each negedge advances the miss sequence.
                    miss_q <= miss_d;
                    wb_q   <= wb_d;
                    if (cache_hit) begin
                        rdata_q <= wren_q ? 3'd0 : cache_dataOUT;
                        err_q   <= 1'b0;
                        ack0_q  <= ~last_grant_q;
                        ack1_q  <= last_grant_q;
                        state_q <= RESP;
                    end else if (try_q == TRY_LAST) begin
                        rdata_q <= 3'd0;
                        err_q   <= 1'b1;
                        ack0_q  <= ~last_grant_q;
                        ack1_q  <= last_grant_q;
                        state_q <= RESP;
                    end else begin
                        try_q <= try_q + 3'd1;
                    end
                end
                RESP: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    wren_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0          = ack0_q;
    assign ack1          = ack1_q;
    assign rdata         = rdata_q;
    assign err           = err_q;
    assign busy          = busy_q;
    assign cache_address = addr_q;
    assign cache_data    = data_q;
    assign cache_wren    = wren_q;
    assign miss_count    = miss_q;
    assign wb_count      = wb_q;

endmodule

// File: tb/tb_l1_cache_arbiter.sv
// Bench for l1_cache_arbiter: a behavioural 2-way write-back cache on the cache port, two queued
// requesters, and a transaction-level reference that predicts grants, ack timing, data and counters.
module tb_l1_cache_arbiter;
    localparam int MT = 6;
    localparam int LOGN = 8192;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       req0, req1, we0, we1;
    logic [4:0] addr0, addr1;
    logic [2:0] wdata0, wdata1;
    logic       ack0, ack1, err, busy, cache_wren;
    logic [2:0] rdata, cache_data;
    logic [4:0] cache_address;
    logic [2:0] cache_dataOUT = 3'd0;
    logic       cache_hit = 1'b0;
    logic       cache_write_back_en = 1'b0;
    logic [7:0] miss_count, wb_count;

    logic       cur_r [2];
    logic [4:0] cur_a [2];
    logic [2:0] cur_d [2];
    logic       cur_w [2];

    assign req0 = cur_r[0];
    assign req1 = cur_r[1];
    assign addr0 = cur_a[0];
    assign addr1 = cur_a[1];
    assign wdata0 = cur_d[0];
    assign wdata1 = cur_d[1];
    assign we0 = cur_w[0];
    assign we1 = cur_w[1];

    l1_cache_arbiter #(.MAX_TRIES(MT)) dut (
        .clock(clock), .resetn(resetn),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
        .cache_address(cache_address), .cache_data(cache_data), .cache_wren(cache_wren),
        .cache_dataOUT(cache_dataOUT), .cache_hit(cache_hit),
        .cache_write_back_en(cache_write_back_en),
        .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Cache environment: 4 sets x 2 ways, write-back, evaluated every negedge.
    logic [2:0] mem [32];
    bit         cv [4][2];
    bit         cd [4][2];
    logic [2:0] ctag [4][2];
    logic [2:0] cdat [4][2];
    bit         clru [4];
    bit         cpend = 0;
    bit         force_miss = 0;
    bit         hit_log [LOGN];
    bit         wb_log [LOGN];

    always @(negedge clock) begin : cache_model
        logic [1:0] ix;
        logic [2:0] tg;
        int w, vw;
        cache_dataOUT = 3'($urandom_range(0, 7));
        cache_hit = 1'b0;
        cache_write_back_en = 1'b0;
        if (!force_miss && !$isunknown({cache_address, cache_data, cache_wren})) begin
            ix = cache_address[1:0];
            tg = cache_address[4:2];
            w = -1;
            for (int k = 0; k < 2; k++) if (cv[ix][k] && ctag[ix][k] == tg) w = k;
            if (w >= 0) begin
                if (cache_wren) begin
                    cdat[ix][w] = cache_data;
                    cd[ix][w] = 1;
                end
                cache_dataOUT = cdat[ix][w];
                cache_hit = 1'b1;
                clru[ix] = (w == 0);
                cpend = 0;
            end else begin
                vw = !cv[ix][0] ? 0 : (!cv[ix][1] ? 1 : int'(clru[ix]));
                if (cv[ix][vw] && cd[ix][vw]) begin
                    mem[{ctag[ix][vw], ix}] = cdat[ix][vw];
                    cd[ix][vw] = 0;
                    cache_write_back_en = 1'b1;
                end else if (!cpend) begin
                    cpend = 1;
                end else begin
                    cv[ix][vw] = 1;
                    cd[ix][vw] = 0;
                    ctag[ix][vw] = tg;
                    cdat[ix][vw] = mem[cache_address];
                    cpend = 0;
                end
            end
        end
        hit_log[cyc % LOGN] = cache_hit;
        wb_log[cyc % LOGN] = cache_write_back_en;
    end

    typedef struct packed {
        logic [4:0] a;
        logic [2:0] d;
        logic       w;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];

    int errors = 0;
    int checks = 0;

    // Reference state: memory image as seen through a transparent cache, arbitration and counters.
    logic [2:0] mem_ref [32];
    int         ph = 0;
    int         g = 0;
    int         acc_edge = 0;
    bit         ref_last = 1;
    int         exp_miss = 0;
    int         exp_wb = 0;
    logic [4:0] exp_ca = 5'd0;
    logic [2:0] exp_cd = 3'd0;
    logic       exp_cw = 1'b0;

    int         obs_start = 0;
    int         obs_lat = 0;
    logic [2:0] obs_rd = 3'd0;
    logic       obs_err = 1'b0;
    int         order[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int r, input logic [4:0] a, input logic [2:0] d, input logic w);
        txn_t x;
        x.a = a;
        x.d = d;
        x.w = w;
        if (r == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic load(input int r);
        txn_t x;
        if (r == 0 && q0.size() > 0) begin
            x = q0.pop_front();
            cur_a[0] = x.a; cur_d[0] = x.d; cur_w[0] = x.w; cur_r[0] = 1'b1;
        end else if (r == 1 && q1.size() > 0) begin
            x = q1.pop_front();
            cur_a[1] = x.a; cur_d[1] = x.d; cur_w[1] = x.w; cur_r[1] = 1'b1;
        end else begin
            cur_r[r] = 1'b0;
        end
    endtask

    task automatic cycle();
        int t, j;
        bit h, e_ack;
        logic e_err;
        logic [2:0] e_rd;
        @(posedge clock);
        #1;
        t = cyc;
        e_ack = 0;
        e_err = 1'b0;
        e_rd = 3'd0;
        if (!resetn) begin
            ph = 0; exp_miss = 0; exp_wb = 0; ref_last = 1;
            exp_ca = 5'd0; exp_cd = 3'd0; exp_cw = 1'b0;
            chk("rst_err", err, 0);
            chk("rst_rdata", rdata, 0);
        end else begin
            case (ph)
                0: begin
                    if (cur_r[0] || cur_r[1]) begin
                        g = (cur_r[0] && cur_r[1]) ? (ref_last ? 0 : 1) : (cur_r[0] ? 0 : 1);
                        acc_edge = t;
                        ph = 1;
                        exp_ca = cur_a[g]; exp_cd = cur_d[g]; exp_cw = cur_w[g];
                    end else begin
                        exp_cw = 1'b0;
                    end
                end
                1: begin
                    j = t - acc_edge;
                    h = hit_log[(t - 1) % LOGN];
                    if (j == 1 && !h && exp_miss < 255) exp_miss++;
                    if (wb_log[(t - 1) % LOGN] && exp_wb < 255) exp_wb++;
                    if (h || j == MT) begin
                        e_ack = 1;
                        e_err = !h;
                        e_rd = (h && !exp_cw) ? mem_ref[exp_ca] : 3'd0;
                        if (h && exp_cw) mem_ref[exp_ca] = exp_cd;
                        ref_last = (g == 1);
                        ph = 2;
                    end
                end
                default: begin
                    ph = 0;
                    exp_cw = 1'b0;
                end
            endcase
        end
        chk("ack0", ack0, e_ack && g == 0);
        chk("ack1", ack1, e_ack && g == 1);
        chk("busy", busy, ph != 0);
        chk("cache_address", cache_address, exp_ca);
        chk("cache_data", cache_data, exp_cd);
        chk("cache_wren", cache_wren, exp_cw);
        chk("miss_count", miss_count, exp_miss);
        chk("wb_count", wb_count, exp_wb);
        if (e_ack) begin
            chk("err", err, e_err);
            chk("rdata", rdata, e_rd);
        end
        if (busy === 1'b1 && t - 1 > obs_start && obs_lat >= 0 && !(ack0 || ack1) && ph == 1 && t == acc_edge)
            obs_start = t;
        if (ack0 === 1'b1 || ack1 === 1'b1) begin
            obs_lat = t - obs_start;
            obs_rd = rdata;
            obs_err = err;
            order.push_back(ack1 === 1'b1 ? 1 : 0);
            $display("txn: cycle %0d ack%0d lat=%0d rdata=%0h err=%0b miss=%0d wb=%0d",
                     t, (ack1 === 1'b1) ? 1 : 0, obs_lat, rdata, err, miss_count, wb_count);
        end
        if (resetn) begin
            if (ack0 === 1'b1) load(0);
            if (ack1 === 1'b1) load(1);
            if (!cur_r[0]) load(0);
            if (!cur_r[1]) load(1);
        end
    endtask

    task automatic run_until_idle(input int bound);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(q0.size() == 0 && q1.size() == 0 && !cur_r[0] && !cur_r[1] && ph == 0)
                   && n < bound);
        chk("drain_in_budget", n < bound, 1);
    endtask

    int m0, w0;

    initial begin
        for (int k = 0; k < 32; k++) begin
            mem[k] = 3'($urandom_range(0, 7));
            mem_ref[k] = mem[k];
        end
        for (int r = 0; r < 2; r++) begin
            cur_r[r] = 1'b0; cur_a[r] = 5'd0; cur_d[r] = 3'd0; cur_w[r] = 1'b0;
        end

        repeat (3) cycle();
        resetn = 1'b1;
        repeat (4) cycle();
        chk("idle_miss_zero", miss_count, 0);
        chk("idle_wb_zero", wb_count, 0);

        // Write then read of the same line.
        push(0, 5'h0A, 3'b101, 1'b1);
        run_until_idle(50);
        chk("wr_lat_le4", obs_lat <= 4, 1);
        chk("wr_rdata", obs_rd, 3'b000);
        chk("wr_err", obs_err, 0);
        m0 = int'(miss_count);
        push(0, 5'h0A, 3'b000, 1'b0);
        run_until_idle(50);
        chk("rd_lat", obs_lat, 1);
        chk("rd_rdata", obs_rd, 3'b101);
        chk("rd_miss_same", miss_count, m0);

        // Dirty eviction in set 2.
        push(0, 5'h02, 3'b001, 1'b1);
        push(0, 5'h06, 3'b010, 1'b1);
        run_until_idle(100);
        w0 = int'(wb_count);
        push(0, 5'h0A, 3'b000, 1'b0);
        run_until_idle(50);
        chk("dirty_wb_inc", wb_count, w0 + 1);
        chk("dirty_lat", obs_lat, 4);
        chk("dirty_rdata", obs_rd, 3'b101);
        m0 = int'(miss_count);
        push(0, 5'h02, 3'b000, 1'b0);
        run_until_idle(50);
        chk("refetch_rdata", obs_rd, 3'b001);
        chk("refetch_miss_inc", miss_count, m0 + 1);

        // Reset in the middle of a transaction.
        push(0, 5'h1D, 3'b000, 1'b0);
        repeat (3) cycle();
        resetn = 1'b0;
        cur_r[0] = 1'b0;
        cur_r[1] = 1'b0;
        q0.delete();
        q1.delete();
        repeat (3) cycle();
        chk("rst_busy", busy, 0);
        resetn = 1'b1;
        repeat (4) cycle();
        chk("post_rst_miss", miss_count, 0);
        chk("post_rst_wb", wb_count, 0);

        // Round-robin with both requesters held high.
        order.delete();
        push(0, 5'h0A, 3'd0, 1'b0);
        push(1, 5'h02, 3'd0, 1'b0);
        push(0, 5'h06, 3'd0, 1'b0);
        push(1, 5'h0A, 3'd0, 1'b0);
        run_until_idle(100);
        chk("rr_count", order.size(), 4);
        for (int k = 0; k < order.size() && k < 4; k++) chk("rr_order", order[k], k % 2);

        // Timeout with the cache never hitting.
        force_miss = 1;
        push(1, 5'h11, 3'd0, 1'b0);
        run_until_idle(50);
        chk("to_err", obs_err, 1);
        chk("to_lat", obs_lat, MT);
        chk("to_rdata", obs_rd, 3'b000);
        chk("to_idle_busy", busy, 0);

        // Miss counter saturation.
        for (int k = 0; k < 260; k++)
            push(k % 2, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        run_until_idle(5000);
        chk("miss_saturated", miss_count, 255);
        force_miss = 0;
        repeat (4) cycle();

        // Random mixed traffic.
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 20; k++)
                push(int'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            run_until_idle(1000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l1_cache_arbiter.md
# l1_cache_arbiter

Sequencer and two-port arbiter in front of the 2-way write-back L1 cache. It accepts read/write requests from two requesters and grants them round-robin. It presents the granted request to the cache and holds it stable until the cache reports a hit, which covers write-back, fetch and fill. It then returns the data with a one-cycle acknowledge. It also keeps the cache inputs benign while idle and counts misses and write-backs.

## Interface
- MAX_TRIES, 6, cache evaluations allowed per transaction before aborting with err (3..7).
- clock  in  1  system clock; arbiter logic on posedge, cache evaluates on negedge.
- resetn  in  1  one clock; reset is synchronous and active-low.
- req0 / req1  in  1  request from requester 0 / 1; held high until own ack.
- addr0 / addr1  in  5  request address {tag[2:0], index[1:0]}.
- wdata0 / wdata1  in  3  write data.
- we0 / we1  in  1  1 = write, 0 = read.
- ack0 / ack1  out  1  one-cycle completion pulse to requester 0 / 1.
- rdata  out  3  read data, valid while ack0|ack1; 3'b000 for writes.
- err  out  1  valid with ack; 1 = MAX_TRIES exhausted without hit.
- busy  out  1  transaction in flight (state != IDLE).
- cache_address  out  5  to cache address.
- cache_data  out  3  to cache data.
- cache_wren  out  1  to cache wren.
- cache_dataOUT  in  3  from cache dataOUT.
- cache_hit  in  1  from cache hit.
- cache_write_back_en  in  1  from cache write_back_en.
- miss_count  out  8  transactions whose first evaluation missed; saturates at 255.
- wb_count  out  8  BUSY cycles sampling cache_write_back_en=1; saturates at 255.

## Operation
- States: IDLE, BUSY, RESP. All outputs registered.
- IDLE:
  - Drive the last cache_address with cache_wren=0. The cache has no enable, so it re-reads a resident line every negedge.
  - If any req is high: choose the grantee, latch its addr/wdata/we into cache_address/cache_data/cache_wren, clear try counter, go BUSY.
- Arbitration:
  - One request pending: grant it.
  - Both pending: grant the one not granted last. last_grant resets to 1, so requester 0 wins the first tie.
- BUSY (each posedge, sampling the preceding negedge's cache result):
  - Cache inputs held unchanged. Repeated evaluation steps the cache through write-back, fetch-setup and fill until the line is resident.
  - cache_hit=1: rdata <= cache_dataOUT, err <= 0, go RESP.
  - Miss and try counter == MAX_TRIES-1: rdata <= 0, err <= 1, go RESP.
  - Otherwise increment the try counter.
  - First sample of a transaction = miss: miss_count += 1 (saturating).
  - cache_write_back_en sampled 1: wb_count += 1 (saturating).
- RESP (one cycle): ack of the grantee high, busy high. Then go IDLE; cache_wren <= 0, cache_address unchanged.
- req lines are sampled only in IDLE. A req still high on the edge leaving RESP is taken as a new request at the next IDLE edge.
- Reset (resetn low at posedge, any state, including mid-transaction):
  - state=IDLE; ack0=ack1=0, err=0, busy=0, rdata=0.
  - cache_address=0, cache_data=0, cache_wren=0; counters=0, last_grant=1.
  - An in-flight transaction is dropped with no ack. Cache contents are not reset.

## Timing
- Edge E0: request accepted, cache_* updated. Negedge after En = evaluation n+1, sampled at E(n+1).
- Hit: sampled at E1, ack high during cycle E1-E2. Latency 1.
- Clean miss: miss at E1, fill at E2, hit at E3. Ack after E3.
- Dirty miss: write-back at E1, fetch-setup at E2, fill at E3, hit at E4. Ack after E4.
- Default MAX_TRIES=6 leaves 2 cycles of margin. err path: ack after E(MAX_TRIES).
- Minimum spacing between grants: 3 cycles for a hit (accept, BUSY, RESP).
- A stale cache_hit present at E0 is never used; sampling starts at E1.

## Test plan
- Reset: hold resetn=0 3 cycles mid-BUSY -> all outputs 0, no ack; after release, idle 4 cycles, counters stay 0 until a request.
- Write then read: req0 we=1 addr=5'h0A wdata=3'b101 -> ack0 within 4 cycles, rdata=000, err=0. Then req0 read 5'h0A -> ack0 exactly 1 cycle after accept, rdata=101, miss_count unchanged.
- Dirty eviction: write 5'h02=001, write 5'h06=010, read 5'h0A -> wb_count increments by 1, ack 4 cycles after accept. Then read 5'h02 -> rdata=001 from memory, miss_count increments.
- Round-robin: req0 and req1 high together continuously -> grants alternate 0,1,0,1. Each ack pulses one cycle and ack0/ack1 are never high together.
- Timeout: tie cache_hit=0 in the bench -> ack with err=1 after E6, rdata=000, then IDLE with busy=0.
- Saturation: 260 forced-miss transactions -> miss_count holds at 255.
